// File: rtl/mealy_fsm_pkg.sv
// Shared constants and elaboration-time helpers for the mealy_fsm sequence detector.
package mealy_fsm_pkg;

    localparam int unsigned MAX_PAT_LEN  = 16;
    localparam int unsigned DFLT_PAT_LEN = 4;
    localparam logic [MAX_PAT_LEN-1:0] DFLT_PATTERN = 16'b1101;

    // State holds the matched prefix length 0..len-1.
    function automatic int unsigned state_w(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    // Longest proper prefix of pat that is a suffix of (prefix of length st, then b).
    function automatic int unsigned prefix_suffix_len(input logic [MAX_PAT_LEN-1:0] pat,
                                                      input int unsigned len,
                                                      input int unsigned st,
                                                      input logic b);
        logic [MAX_PAT_LEN:0] seq;
        int unsigned          n;
        int unsigned          best;
        logic                 ok;
        seq  = '0;
        n    = st + 1;
        best = 0;
        for (int unsigned j = 0; j < MAX_PAT_LEN; j++) begin
            if (j < st && j < len) seq[j] = pat[len-1-j];
        end
        if (st <= MAX_PAT_LEN) seq[st] = b;
        for (int unsigned k = 1; k < MAX_PAT_LEN; k++) begin
            if (k < len && k <= n) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < k) begin
                        if (pat[len-1-i] != seq[n-k+i]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic int unsigned next_state(input logic [MAX_PAT_LEN-1:0] pat,
                                               input int unsigned len,
                                               input logic overlap,
                                               input int unsigned st,
                                               input logic b);
        if (st >= len) return 0;
        if (st == len - 1 && b == pat[0]) return overlap ? prefix_suffix_len(pat, len, st, b) : 0;
        return prefix_suffix_len(pat, len, st, b);
    endfunction

endpackage

// File: rtl/mealy_fsm_table.sv
// Combinational (state, inp) -> (next state, match) lookup, built from constants at elaboration.
module mealy_fsm_table
    import mealy_fsm_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DFLT_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DFLT_PATTERN),
    parameter logic                 OVERLAP = 1'b1,
    parameter int unsigned          SW      = state_w(PAT_LEN)
) (
    input  logic [SW-1:0] state_i,
    input  logic          inp_i,
    output logic [SW-1:0] next_state_o,
    output logic          match_o
);

    localparam int unsigned NENT = 2 ** (SW + 1);

    logic [SW-1:0] ns_tbl [NENT];

    // Entries for encodings >= PAT_LEN resolve to 0 inside next_state().
    for (genvar e = 0; e < NENT; e++) begin : g_ent
        localparam int unsigned NS = next_state(MAX_PAT_LEN'(PATTERN), PAT_LEN, OVERLAP,
                                                int'(e) / 2, 1'(e % 2));
        assign ns_tbl[e] = SW'(NS);
    end

    assign next_state_o = ns_tbl[{state_i, inp_i}];
    assign match_o      = (state_i == SW'(PAT_LEN - 1)) && (inp_i == PATTERN[0]);

endmodule

// File: rtl/mealy_fsm.sv
// Mealy serial pattern detector: state register with async active-low reset and match strobe.
module mealy_fsm
    import mealy_fsm_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DFLT_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DFLT_PATTERN),
    parameter logic                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic outp
);

    localparam int unsigned SW = state_w(PAT_LEN);

    typedef logic [SW-1:0] state_t;

    state_t state_q;
    state_t state_d;
    state_t tbl_next;
    logic   tbl_match;

    mealy_fsm_table #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_table (
        .state_i      (state_q),
        .inp_i        (inp),
        .next_state_o (tbl_next),
        .match_o      (tbl_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= '0;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = tbl_next;
    end

    always_comb begin
        outp = tbl_match;
    end

endmodule

// File: tb/tb_mealy_fsm.sv
// Directed bench for mealy_fsm: default pattern 1101 with overlap on and off side by side.
module tb_mealy_fsm;

    logic clk;
    logic rst;
    logic inp;
    logic outp_ov1;
    logic outp_ov0;

    int n_checks;
    int n_fail;

    mealy_fsm dut_ov1 (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .outp (outp_ov1)
    );

    mealy_fsm #(
        .OVERLAP (1'b0)
    ) dut_ov0 (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .outp (outp_ov0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered at a negedge: apply bit, check strobe mid-cycle, advance to next negedge.
    task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] exp1, input logic [15:0] exp0);
        for (int i = 0; i < n; i++) begin
            inp = bits[n-1-i];
            #1;
            check1($sformatf("%s_ov1_bit%0d", tag, i + 1), outp_ov1, exp1[n-1-i]);
            check1($sformatf("%s_ov0_bit%0d", tag, i + 1), outp_ov0, exp0[n-1-i]);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        inp = 1'b1;
        #1;
        check1("rst_outp_a", outp_ov1, 1'b0);
        @(posedge clk); #1;
        check1("rst_outp_b", outp_ov1, 1'b0);
        check_st("rst_state_b", dut_ov1.state_q, 2'd0);
        @(posedge clk); #1;
        check1("rst_outp_c", outp_ov1, 1'b0);
        check1("rst_outp_c_ov0", outp_ov0, 1'b0);
        check_st("rst_state_c", dut_ov1.state_q, 2'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        inp      = 1'b0;
        @(negedge clk);

        do_reset();
        run_seq("basic", 4, 16'b1101, 16'b0001, 16'b0001);

        do_reset();
        run_seq("overlap", 7, 16'b1101101, 16'b0001001, 16'b0001000);

        do_reset();
        run_seq("selfloop", 5, 16'b11101, 16'b00001, 16'b00001);

        do_reset();
        run_seq("falsestart", 7, 16'b1011001, 16'b0000000, 16'b0000000);

        do_reset();
        run_seq("b2b", 8, 16'b11011101, 16'b00010001, 16'b00010001);

        // Reaching S3 with 1,1,0 then resetting between edges must drop the partial match.
        do_reset();
        run_seq("pre_mid", 3, 16'b110, 16'b000, 16'b000);
        check_st("pre_mid_state", dut_ov1.state_q, 2'd3);
        #2;
        rst = 1'b0;
        #1;
        check_st("mid_rst_state", dut_ov1.state_q, 2'd0);
        inp = 1'bx;
        #1;
        check1("mid_rst_x_outp", outp_ov1, 1'b0);
        inp = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        run_seq("post_mid", 1, 16'b1, 16'b0, 16'b0);
        do_reset();
        run_seq("post_mid_match", 4, 16'b1101, 16'b0001, 16'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
